// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: ROM geometry defaults and the two-requester grant rule.
package rom_port_arbiter_pkg;

    localparam int ROM_DEPTH_LOG = 12;
    localparam int ROM_WIDTH     = 32;

    // Returns {grant1, grant0}; prio only matters when both are eligible.
    function automatic logic [1:0] arb_grant(input logic e0, input logic e1, input logic prio);
        return {e1 & (~e0 | prio), e0 & (~e1 | ~prio)};
    endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// rom_rsp_slot: one requester's in-flight flag and held response register.
module rom_rsp_slot
    import rom_port_arbiter_pkg::*;
#(
    parameter int WIDTH = ROM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_grant,
    input  logic [WIDTH-1:0] i_rom_dout,
    input  logic             i_rsp_ready,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_free
);

    logic             r_inflight;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_inflight <= i_grant;
            if (r_inflight) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= i_rom_dout;
            end else if (i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // A held response being consumed this cycle frees the slot for a new grant.
    assign o_free      = ~r_inflight & (~r_rsp_valid | i_rsp_ready);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one registered ROM read port between two requesters
// with alternating priority and a fixed two-cycle response latency.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG = ROM_DEPTH_LOG,
    parameter int WIDTH     = ROM_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [DEPTH_LOG-1:0] req0_addr,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DEPTH_LOG-1:0] req1_addr,
    output logic                 req1_ready,
    output logic                 rsp0_valid,
    output logic [WIDTH-1:0]     rsp0_data,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    output logic [WIDTH-1:0]     rsp1_data,
    input  logic                 rsp1_ready,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_dout
);

    logic       r_prio;
    logic       w_free0;
    logic       w_free1;
    logic       w_elig0;
    logic       w_elig1;
    logic [1:0] w_grant;

    // Reset gating keeps ready low while reset is held even though slots read as free.
    assign w_elig0 = req0_valid & w_free0 & ~reset;
    assign w_elig1 = req1_valid & w_free1 & ~reset;
    assign w_grant = arb_grant(w_elig0, w_elig1, r_prio);

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rom_addr   = w_grant[0] ? req0_addr : w_grant[1] ? req1_addr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_prio <= 1'b0;
        else if (|w_grant)
            r_prio <= w_grant[0];
    end

    rom_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk         (clk),
        .reset       (reset),
        .i_grant     (w_grant[0]),
        .i_rom_dout  (rom_dout),
        .i_rsp_ready (rsp0_ready),
        .o_rsp_valid (rsp0_valid),
        .o_rsp_data  (rsp0_data),
        .o_free      (w_free0)
    );

    rom_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .i_grant     (w_grant[1]),
        .i_rom_dout  (rom_dout),
        .i_rsp_ready (rsp1_ready),
        .o_rsp_valid (rsp1_valid),
        .o_rsp_data  (rsp1_data),
        .o_free      (w_free1)
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and random stimulus checked against a
// transaction-level model of grants, priority and two-cycle responses.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [11:0] req0_addr = '0, req1_addr = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [11:0] rom_addr;
    logic [31:0] rom_dout = '0;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;

    bit          m_pend[2];
    int          m_due[2];
    logic [11:0] m_paddr[2];
    bit          m_have[2];
    logic [31:0] m_data[2];
    bit          m_prio;

    always #5 clk = ~clk;

    rom_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout)
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {4'hC, a, 4'h5, ~a};
    endfunction

    // Synchronous ROM: address registered on clk, data available next cycle.
    always @(posedge clk) rom_dout <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 2; n++) begin
            m_pend[n] = 0;
            m_have[n] = 0;
        end
        m_prio = 0;
    endtask

    task automatic cyc(input bit v0, input logic [11:0] a0, input bit r0,
                       input bit v1, input logic [11:0] a1, input bit r1);
        bit r[2];
        bit e[2];
        bit g0, g1;
        logic [11:0] ea;
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
        req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
        #1;
        r[0] = r0; r[1] = r1;
        e[0] = v0 && !m_pend[0] && (!m_have[0] || r0);
        e[1] = v1 && !m_pend[1] && (!m_have[1] || r1);
        g0 = e[0] && (!e[1] || !m_prio);
        g1 = e[1] && !g0;
        ea = g0 ? a0 : (g1 ? a1 : 12'h000);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("rom_addr", rom_addr, ea);
        chk("rsp0_valid", rsp0_valid, m_have[0]);
        chk("rsp1_valid", rsp1_valid, m_have[1]);
        if (m_have[0]) chk("rsp0_data", rsp0_data, m_data[0]);
        if (m_have[1]) chk("rsp1_data", rsp1_data, m_data[1]);
        for (int n = 0; n < 2; n++) begin
            if (m_have[n] && r[n]) m_have[n] = 0;
            if (m_pend[n] && m_due[n] == cyc_n + 1) begin
                m_have[n] = 1;
                m_data[n] = rom_word(m_paddr[n]);
                m_pend[n] = 0;
            end
        end
        if (g0) begin m_pend[0] = 1; m_due[0] = cyc_n + 2; m_paddr[0] = a0; m_prio = 1; end
        if (g1) begin m_pend[1] = 1; m_due[1] = cyc_n + 2; m_paddr[1] = a1; m_prio = 0; end
        cyc_n++;
    endtask

    // Requests stay asserted during reset so ready gating is exercised.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        repeat (n) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset(2);

        // single request, two-cycle latency
        cyc(1, 12'h010, 1, 0, 0, 0);
        chk("lat_ready", req0_ready, 1);
        chk("lat_addr", rom_addr, 12'h010);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("lat_rsp", rsp0_valid, 1);
        chk("lat_data", rsp0_data, rom_word(12'h010));

        // both requesters alternate from reset
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 12'h001, 1, 1, 12'h002, 1);
            chk("alt_grant", req1_ready, i % 2);
        end

        // lone requester served every other cycle
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 12'(12'h100 + i), 1, 0, 0, 1);
            chk("lone_grant", req0_ready, (i % 2) == 0);
        end

        // stalled response on requester 1
        do_reset(1);
        cyc(0, 0, 1, 1, 12'h0AB, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 12'(12'h200 + i), 1, 1, 12'h0CD, 0);
            chk("stall_data", rsp1_data, rom_word(12'h0AB));
            chk("stall_ready1", req1_ready, 0);
        end
        cyc(0, 0, 1, 0, 0, 1);

        // reset right after a grant drops the in-flight read
        do_reset(1);
        cyc(1, 12'h020, 1, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("drop_rsp0", rsp0_valid, 0);
        cyc(1, 12'h030, 1, 1, 12'h031, 1);
        chk("prio_after_rst", req0_ready, 1);

        // consume and re-request on the arrival cycle
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1, 12'(12'h300 + i), 1, 0, 0, 0);

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)), $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)), $urandom_range(0, 9) < 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 12, ROM address width in words.
REQ-002 SHALL have parameter WIDTH, default 32, ROM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  read request from requester 0 / 1.
REQ-006 SHALL have ports req0_addr / req1_addr  input  DEPTH_LOG  word address of the request.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle (combinational).
REQ-008 SHALL have ports rsp0_valid / rsp1_valid  output  1  response data held for the requester.
REQ-009 SHALL have ports rsp0_data / rsp1_data  output  WIDTH  response word.
REQ-010 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester consumes response.
REQ-011 SHALL have port rom_addr  output  DEPTH_LOG  address driven to the shared ROM read port (ROM registers it on clk).
REQ-012 SHALL have port rom_dout  input  WIDTH  ROM read data, valid one cycle after rom_addr is presented.

Function
REQ-013 SHALL treat a request as accepted in a cycle where reqN_valid and reqN_ready are both 1.
REQ-014 SHALL define slotN free when inflightN=0 and (rspN_valid=0 or rspN_ready=1).
REQ-015 SHALL make requester N eligible when reqN_valid=1 and slotN is free; at most one grant per cycle.
REQ-016 SHALL grant the single eligible requester when only one is eligible, regardless of priority pointer.
REQ-017 SHALL, when both are eligible, grant the requester indicated by priority pointer prio (0 or 1).
REQ-018 SHALL set prio to the non-granted requester after every grant; prio unchanged in cycles without a grant.
REQ-019 SHALL drive reqN_ready=1 only in the cycle requester N is granted.
REQ-020 SHALL drive rom_addr combinationally with the granted address; all-zero when no grant.
REQ-021 SHALL set inflightN on the edge ending the grant cycle and clear it on the following edge.
REQ-022 SHALL capture rom_dout into rspN_data and set rspN_valid on the edge ending the cycle in which inflightN=1.
REQ-023 SHALL give a fixed latency of 2 cycles: accept in cycle t -> rspN_valid high from cycle t+2.
REQ-024 SHALL hold rspN_valid and rspN_data stable until rspN_valid and rspN_ready are both 1; clear rspN_valid on that edge unless a new capture occurs on the same edge.
REQ-025 SHALL allow at most one outstanding read per requester; a single requester alone is served at most once per 2 cycles; alternating requesters sustain one grant per cycle.
REQ-026 SHALL ignore rspN_ready while rspN_valid=0.
REQ-027 SHALL keep reqN_addr irrelevant outside the grant cycle (not registered).

Reset
REQ-028 SHALL on reset asynchronously clear prio to 0, inflight0/1 to 0, rsp0/1_valid to 0, rsp0/1_data to 0.
REQ-029 SHALL discard any in-flight read when reset asserts mid-operation; no response delivered after reset release for requests accepted before reset.
REQ-030 SHALL drive req0/1_ready=0 while reset is asserted.

Structure
REQ-031 SHALL implement as a single module; per-requester slot logic (inflight flag, response register) MAY be one sub-module rom_rsp_slot instantiated twice.
REQ-032 SHALL place no typedefs in a shared package; DEPTH_LOG and WIDTH defaults SHALL match the ROM's defaults (12, 32).

Verification
REQ-033 SHALL cover: after reset, req0_valid=1 addr=0x010, rsp0_ready=1 -> req0_ready in cycle 0, rom_addr=0x010, rsp0_valid cycle 2 with ROM[0x010].
REQ-034 SHALL cover: both valid from reset (addr0=0x001, addr1=0x002), rsp ready=1 -> grants 0,1,0,1 on consecutive cycles, data matches per address.
REQ-035 SHALL cover: req0 only, continuously valid, rsp0_ready=1 -> req0_ready every other cycle, responses in order.
REQ-036 SHALL cover: rsp1_ready=0 for 5 cycles after response -> rsp1_data held stable, req1_ready=0 throughout, req0 still served.
REQ-037 SHALL cover: reset asserted in cycle after grant of 0x020 -> no rsp0_valid after release, prio=0.
REQ-038 SHALL cover: rsp0_ready=1 in same cycle inflight0 data arrives with new request pending -> back-to-back rsp0_valid without drop or duplicate.
